// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump sequencer: FSM state encoding,
// default bytes-per-register and the byte-counter width helper.
package regdump_pkg;

    // Checksum states are always encoded so every build shares one state type.
    typedef enum logic [3:0] {
        IDLE,
        SET_ADDR,
        LATCH,
        SEND,
        WAIT_TX,
        NEXT,
        DONE,
        CKSUM_SEND,
        CKSUM_WAIT
    } dump_state_t;

    localparam int DEFAULT_NBITS = 32;
    localparam int DEFAULT_BYTE  = 8;
    localparam int BYTES_PER_REG = DEFAULT_NBITS / DEFAULT_BYTE;

    function automatic int byte_cnt_w(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/regdump_byte_sel.sv
// Combinational byte selector: picks byte <idx> (byte 0 = least significant)
// out of an NBITS word. Shared with the memory dump path.
module regdump_byte_sel #(
    parameter int NBITS = 32,
    parameter int BYTE  = 8,
    parameter int IDX_W = 2
) (
    input  logic [NBITS-1:0] data,
    input  logic [IDX_W-1:0] idx,
    output logic [BYTE-1:0]  byte_out
);

    always_comb begin
        byte_out = '0;
        for (int i = 0; i < NBITS / BYTE; i++) begin
            if (idx == IDX_W'(i)) begin
                byte_out = data[i*BYTE +: BYTE];
            end
        end
    end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Walks the register file debug port and streams every register, LSB byte
// first, to the UART TX. Optional trailing XOR checksum byte: REGDUMP_CHECKSUM_EN.
module regfile_dump_ctrl
    import regdump_pkg::*;
#(
    parameter int NBITS   = 32,
    parameter int REGS    = 5,
    parameter int TAM_REG = 32,
    parameter int BYTE    = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    output logic [REGS-1:0]  o_dir_debug,
    input  logic [NBITS-1:0] i_data_debug,
    output logic [BYTE-1:0]  o_tx_data,
    output logic             o_tx_start,
    input  logic             i_tx_done,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BPR = NBITS / BYTE;
    localparam int BCW = byte_cnt_w(BPR);
    localparam logic [REGS-1:0] LAST_REG  = REGS'(TAM_REG - 1);
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BPR - 1);

    dump_state_t      state, state_nx;
    logic [REGS-1:0]  reg_cnt, reg_cnt_nx;
    logic [BCW-1:0]   byte_cnt, byte_cnt_nx;
    logic [NBITS-1:0] shadow;
    logic [NBITS-1:0] sel_src;
    logic [BYTE-1:0]  sel_byte;
`ifdef REGDUMP_CHECKSUM_EN
    logic [BYTE-1:0]  cksum;
`endif

    assign o_dir_debug = reg_cnt;

    // In LATCH the shadow is not loaded yet, so the first byte comes straight
    // from the debug port; the selector indexes with the upcoming byte count so
    // o_tx_data is valid in the same cycle as o_tx_start.
    assign sel_src = (state == LATCH) ? i_data_debug : shadow;

    regdump_byte_sel #(
        .NBITS (NBITS),
        .BYTE  (BYTE),
        .IDX_W (BCW)
    ) u_byte_sel (
        .data     (sel_src),
        .idx      (byte_cnt_nx),
        .byte_out (sel_byte)
    );

    always_comb begin
        state_nx    = state;
        reg_cnt_nx  = reg_cnt;
        byte_cnt_nx = byte_cnt;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx    = SET_ADDR;
                    reg_cnt_nx  = '0;
                    byte_cnt_nx = '0;
                end
            end
            SET_ADDR: state_nx = LATCH;
            LATCH:    state_nx = SEND;
            SEND:     state_nx = WAIT_TX;
            WAIT_TX: begin
                if (i_tx_done) state_nx = NEXT;
            end
            NEXT: begin
                if (byte_cnt < LAST_BYTE) begin
                    byte_cnt_nx = byte_cnt + BCW'(1);
                    state_nx    = SEND;
                end else begin
                    byte_cnt_nx = '0;
                    if (reg_cnt < LAST_REG) begin
                        reg_cnt_nx = reg_cnt + REGS'(1);
                        state_nx   = SET_ADDR;
                    end else begin
`ifdef REGDUMP_CHECKSUM_EN
                        state_nx = CKSUM_SEND;
`else
                        state_nx = DONE;
`endif
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            CKSUM_SEND: state_nx = CKSUM_WAIT;
            CKSUM_WAIT: begin
                if (i_tx_done) state_nx = DONE;
            end
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one is asserted for
    // exactly the cycles the FSM spends in the corresponding state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            reg_cnt    <= '0;
            byte_cnt   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            cksum      <= '0;
`endif
        end else begin
            state      <= state_nx;
            reg_cnt    <= reg_cnt_nx;
            byte_cnt   <= byte_cnt_nx;
            o_busy     <= (state_nx != IDLE) && (state_nx != DONE);
            o_done     <= (state_nx == DONE);
`ifdef REGDUMP_CHECKSUM_EN
            o_tx_start <= (state_nx == SEND) || (state_nx == CKSUM_SEND);
            if (state == IDLE && i_start) begin
                cksum <= '0;
            end else if (state_nx == SEND) begin
                cksum <= cksum ^ sel_byte;
            end
            if (state_nx == CKSUM_SEND) begin
                o_tx_data <= cksum;
            end
`else
            o_tx_start <= (state_nx == SEND);
`endif
            if (state_nx == SEND) begin
                o_tx_data <= sel_byte;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == LATCH) begin
            shadow <= i_data_debug;
        end
    end

endmodule
